// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter sharing the common data bus among the
// execution units. The grant is combinational; the broadcast is registered.
// Optional feature macro: CDB_ARB_STALLCNT_EN builds the saturating 8-bit
// denied-request counter on stall_count; otherwise stall_count is tied to 0.
module cdb_arbiter #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_FU-1:0]        fu_req,
    input  logic [NUM_FU*ID_W-1:0]   fu_id,
    input  logic [NUM_FU*DATA_W-1:0] fu_val,
    output logic [NUM_FU-1:0]        fu_grant,
    input  logic                     flush,
    output logic                     cdb_valid,
    output logic [ID_W-1:0]          cdb_id,
    output logic [DATA_W-1:0]        cdb_val,
    output logic [7:0]               stall_count
);

    localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  slot_idx;
    int unsigned       slot;
    logic              transfer;
    logic [ID_W-1:0]   win_id;
    logic [DATA_W-1:0] win_val;

    logic              cdb_valid_q;
    logic [ID_W-1:0]   cdb_id_q;
    logic [DATA_W-1:0] cdb_val_q;

    logic [ID_W-1:0]   id_arr  [NUM_FU];
    logic [DATA_W-1:0] val_arr [NUM_FU];

    for (genvar i = 0; i < NUM_FU; i++) begin : g_unpack
        assign id_arr[i]  = fu_id[i*ID_W +: ID_W];
        assign val_arr[i] = fu_val[i*DATA_W +: DATA_W];
    end

    // Search from ptr upward with wrap; the first requester found wins.
    always_comb begin
        fu_grant = '0;
        transfer = 1'b0;
        win_idx  = '0;
        win_id   = '0;
        win_val  = '0;
        slot     = 0;
        slot_idx = '0;
        if (rst && !flush) begin
            for (int unsigned k = 0; k < NUM_FU; k++) begin
                slot     = (32'(ptr_q) + k) % NUM_FU;
                slot_idx = PTR_W'(slot);
                if (!transfer && fu_req[slot_idx]) begin
                    transfer           = 1'b1;
                    fu_grant[slot_idx] = 1'b1;
                    win_idx            = slot_idx;
                    win_id             = id_arr[slot_idx];
                    win_val            = val_arr[slot_idx];
                end
            end
        end
    end

    // Pointer moves just past the winner; held when nothing transfers.
    always_comb begin
        ptr_d = ptr_q;
        if (transfer) begin
            if (win_idx == PTR_W'(NUM_FU - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + 1'b1;
            end
        end
    end

    // Pointer and broadcast register; id/val hold when no transfer occurs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_id_q    <= '0;
            cdb_val_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cdb_valid_q <= transfer;
            if (transfer) begin
                cdb_id_q  <= win_id;
                cdb_val_q <= win_val;
            end
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_id    = cdb_id_q;
    assign cdb_val   = cdb_val_q;

`ifdef CDB_ARB_STALLCNT_EN
    logic [7:0] stall_q;
    logic       stalled;

    // Any request left ungranted this cycle, flush-blocked ones included.
    assign stalled = |(fu_req & ~fu_grant);

    // Saturating counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= 8'd0;
        end else if (stalled && (stall_q != 8'hFF)) begin
            stall_q <= stall_q + 8'd1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 8'd0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (NUM_FU=4, ID_W=4, DATA_W=8).
// A small reference model predicts each grant; broadcasts it predicts are
// queued and popped when the registered CDB output appears.
module tb_cdb_arbiter;

    localparam int NF = 4;
    localparam int IW = 4;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [NF-1:0]     fu_req;
    logic [NF*IW-1:0]  fu_id;
    logic [NF*DW-1:0]  fu_val;
    logic [NF-1:0]     fu_grant;
    logic              cdb_valid;
    logic [IW-1:0]     cdb_id;
    logic [DW-1:0]     cdb_val;
    logic [7:0]        stall_count;

    logic [IW-1:0]     ids  [NF];
    logic [DW-1:0]     vals [NF];

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] val;
    } bcast_t;

    bcast_t        sb[$];
    int            errors = 0;
    int            checks = 0;
    logic [1:0]    m_ptr;
    logic          m_valid;
    logic [IW-1:0] m_id;
    logic [DW-1:0] m_val;
    int            m_stall;

    always #5 clk = ~clk;

    for (genvar i = 0; i < NF; i++) begin : g_pack
        assign fu_id[i*IW +: IW] = ids[i];
        assign fu_val[i*DW +: DW] = vals[i];
    end

    cdb_arbiter #(
        .NUM_FU (NF),
        .ID_W   (IW),
        .DATA_W (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fu_req      (fu_req),
        .fu_id       (fu_id),
        .fu_val      (fu_val),
        .fu_grant    (fu_grant),
        .flush       (flush),
        .cdb_valid   (cdb_valid),
        .cdb_id      (cdb_id),
        .cdb_val     (cdb_val),
        .stall_count (stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NF-1:0] model_grant(input logic [NF-1:0] req, input logic [1:0] p,
                                                  input logic fl, input logic rn);
        logic [NF-1:0] g;
        logic [1:0]    s;
        g = '0;
        if (!rn || fl) return g;
        for (int k = 0; k < NF; k++) begin
            s = p + 2'(k);
            if (req[s]) begin
                g[s] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // One clock cycle with the inputs currently driven: check the grant,
    // advance the model, then check the registered outputs after the edge.
    task automatic step();
        logic [NF-1:0] eg;
        logic [1:0]    w;
        bcast_t        b;
        #1;
        eg = model_grant(fu_req, m_ptr, flush, rst);
        chk("fu_grant", 32'(fu_grant), 32'(eg));
        if (!rst) begin
            m_ptr   = 2'd0;
            m_valid = 1'b0;
            m_id    = '0;
            m_val   = '0;
            m_stall = 0;
            sb.delete();
        end else begin
`ifdef CDB_ARB_STALLCNT_EN
            if (((fu_req & ~eg) != '0) && (m_stall < 255)) m_stall++;
`endif
            m_valid = (eg != '0);
            if (eg != '0) begin
                w = 2'd0;
                for (int k = 0; k < NF; k++) begin
                    if (eg[k]) w = 2'(k);
                end
                sb.push_back('{id: ids[w], val: vals[w]});
                m_ptr = w + 2'd1;
            end
        end
        @(posedge clk);
        #1;
        chk("cdb_valid", 32'(cdb_valid), 32'(m_valid));
        if (m_valid) begin
            if (sb.size() == 0) begin
                chk("scoreboard_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                b     = sb.pop_front();
                m_id  = b.id;
                m_val = b.val;
            end
        end
        chk("cdb_id", 32'(cdb_id), 32'(m_id));
        chk("cdb_val", 32'(cdb_val), 32'(m_val));
        chk("stall_count", 32'(stall_count), 32'(m_stall));
    endtask

    initial begin
        m_ptr   = 2'd0;
        m_valid = 1'b0;
        m_id    = '0;
        m_val   = '0;
        m_stall = 0;
        rst     = 1'b0;
        flush   = 1'b0;
        fu_req  = 4'b1111;
        for (int i = 0; i < NF; i++) begin
            ids[i]  = 4'(i + 1);
            vals[i] = 8'(8'h11 * (i + 1));
        end

        // Reset held two cycles with every unit requesting.
        step();
        step();
        chk("reset_stall", 32'(stall_count), 32'd0);

        // Release: first grant to unit 0, then rotate through all units.
        rst = 1'b1;
        #1;
        chk("first_grant", 32'(fu_grant), 32'b0001);
        repeat (5) step();
        chk("rotate_id_wrap", 32'(cdb_id), 32'd1);
        step();  // grant unit 1, pointer now at 2

        // Pointer at 2 with only units 0 and 1 requesting: wraps to unit 0.
        fu_req = 4'b0011;
        #1;
        chk("wrap_grant", 32'(fu_grant), 32'b0001);
        step();
        chk("after_wrap_grant", 32'(fu_grant), 32'b0010);
        step();

        // Single requester on unit 3 for three cycles: back-to-back broadcasts.
        fu_req  = 4'b1000;
        ids[3]  = 4'd9;
        vals[3] = 8'hA5;
        repeat (3) step();
        chk("single_id", 32'(cdb_id), 32'd9);
        chk("single_val", 32'(cdb_val), 32'hA5);
        fu_req = 4'b0000;
        step();

        // Flush for one cycle blocks the grant; the request wins afterwards.
        fu_req = 4'b0100;
        flush  = 1'b1;
        #1;
        chk("flush_grant", 32'(fu_grant), 32'd0);
        step();
        flush = 1'b0;
        chk("flush_no_valid", 32'(cdb_valid), 32'd0);
        step();
        fu_req = 4'b0000;
        step();

        // Reset with a request pending away from unit 0, then saturate stalls.
        rst    = 1'b0;
        fu_req = 4'b1111;
        step();
        rst = 1'b1;
        #1;
        chk("regrant_after_reset", 32'(fu_grant), 32'b0001);
        repeat (100) step();
`ifdef CDB_ARB_STALLCNT_EN
        chk("stall_100", 32'(stall_count), 32'd100);
`else
        chk("stall_100", 32'(stall_count), 32'd0);
`endif
        repeat (200) step();
`ifdef CDB_ARB_STALLCNT_EN
        chk("stall_sat", 32'(stall_count), 32'd255);
`else
        chk("stall_sat", 32'(stall_count), 32'd0);
`endif
        fu_req = 4'b0000;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter sharing the single common data bus (CDB) among the execution units: ALU, load/store, branch and spare. Each unit holds a result request until granted. The arbiter grants one requester per cycle and registers the winning tag/value onto the broadcast CDB, which feeds the reservation stations and register-rename wakeup. It sits between the units' CDB output stages and the CDB consumers.

## Interface
- NUM_FU, 4: number of requesting functional units, 2..8.
- ID_W, 4: ROB tag width.
- DATA_W, 8: result width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low (asserted when 0).
- fu_req  in  NUM_FU  per-unit request; each unit's cdb_transmit_out.
- fu_id  in  NUM_FU×ID_W  per-unit ROB tag; unit i occupies bits [i*ID_W +: ID_W].
- fu_val  in  NUM_FU×DATA_W  per-unit result, packed the same way.
- fu_grant  out  NUM_FU  one-hot grant; drives each unit's cdb_transmit input.
- flush  in  1  pipeline flush from ROB.
- cdb_valid  out  1  registered broadcast valid.
- cdb_id  out  ID_W  registered broadcast tag.
- cdb_val  out  DATA_W  registered broadcast value.
- stall_count  out  8  saturating denied-request count; see Configuration.

## Operation
- Grant is combinational from fu_req, the round-robin pointer `ptr` and flush.
- Search order: ptr, ptr+1, …, NUM_FU-1, 0, …, ptr-1. The first requester in that order wins.
- fu_grant has at most one bit set. It is all zero when flush=1 or no request is present.
- Transfer to unit i occurs at any edge where fu_req[i] & fu_grant[i].
- The unit must hold req, id and val stable until granted. It drops req in the cycle after the transfer edge, or keeps it high if it has a new result.
- Pointer update on transfer to unit i: ptr <= (i+1) mod NUM_FU. With no transfer, ptr is held. Wrap-around: a grant to unit NUM_FU-1 sets ptr to 0.
- Output register on each edge:
  - cdb_valid <= transfer occurred.
  - On a transfer, cdb_id/cdb_val <= the winner's id/val.
  - With no transfer, cdb_id/cdb_val hold their previous values; only cdb_valid qualifies them.
- Flush behaviour:
  - Flush=1 suppresses grants in that cycle, so the next-cycle cdb_valid is 0.
  - A broadcast already registered is still presented in the flush cycle. The ROB discards it by tag.
  - ptr is unchanged by flush.
- There is no backpressure on the CDB, so every broadcast is accepted by consumers.
- Reset (rst=0 at an edge) forces ptr=0, cdb_valid=0, cdb_id=0, cdb_val=0 and stall_count=0.
  - Reset overrides any transfer in the same cycle.
  - fu_grant is all zero while rst=0.
  - A request pending across reset is re-arbitrated from ptr=0 after release.

## Timing
- Request-to-grant: 0 cycles (combinational) when the unit wins.
- Transfer edge to cdb_valid: 1 cycle.
- Throughput: 1 broadcast per cycle.
- Worst-case wait: NUM_FU-1 cycles after the first cycle a request is presented, assuming continuous competing requests.
- Single requester: granted every cycle it requests, giving back-to-back broadcasts.
- fu_grant depends on fu_req combinationally. Units must not derive fu_req from fu_grant in the same cycle.

## Configuration
- CDB_ARB_STALLCNT_EN defined:
  - Increments stall_count by 1 on each edge where at least one fu_req bit is high and not granted, including requests blocked by flush.
  - Saturates at 255 and clears only on reset.
  - Implemented as one 8-bit register.
- CDB_ARB_STALLCNT_EN undefined: stall_count is tied to 0 and no counter logic is built.

## Test plan
- Reset with fu_req=4'b1111 and rst=0 for 2 cycles -> fu_grant=0, cdb_valid=0, stall_count=0. After release, the first grant is 4'b0001.
- Continuous fu_req=4'b1111 with ids 1,2,3,4 -> grants rotate 0001,0010,0100,1000,0001. cdb_id sequence 1,2,3,4,1 lags one cycle. cdb_valid stays high throughout.
- ptr=2 with fu_req=4'b0011 -> grant 4'b0001 (wraps past units 2 and 3), then ptr=1. Next cycle, with the same requests, grant 4'b0010.
- Single requester unit 3 with id=9, val=8'hA5, held high for 3 cycles -> grant every cycle. cdb_valid=1 with cdb_id=9 and cdb_val=8'hA5 for 3 consecutive cycles, starting one cycle after the first grant.
- Flush for 1 cycle while fu_req=4'b0100 -> fu_grant=0 that cycle and cdb_valid=0 the next cycle. Granted the following cycle, with ptr unchanged.
- With CDB_ARB_STALLCNT_EN, fu_req=4'b1111 for 100 cycles -> stall_count=100. After 300 cycles -> stall_count=255. Without the macro -> stall_count=0 throughout.
